hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall sequencer for the 5-stage RV32 core. Works alongside the EX-stage forwarding mux.
//  Generates stall, flush and bubble controls for three cases:
//   - load-use hazards forwarding cannot cover
//   - taken branches/jumps resolved in EX
//   - multi-cycle data-memory waits
//  Owns a data-memory wait watchdog.
// PARAMETERS
//  LOAD_LAT     1    bubbles per load-use hazard (1 = MEM->EX fwd present, 2 = none); range 1..3
//  MEM_TIMEOUT  255  max consecutive dmem wait cycles before error; range 1..65535
// PORTS
//  clk            in   1  core clock, rising edge
//  rst_n          in   1  async active-low reset
//  id_rs1         in   5  rs1 of instr in ID
//  id_rs2         in   5  rs2 of instr in ID
//  id_use_rs1     in   1  ID instr reads rs1
//  id_use_rs2     in   1  ID instr reads rs2
//  id_ex_memread  in   1  instr in EX is a load
//  id_ex_rd       in   5  rd of instr in EX
//  ex_br_taken    in   1  EX resolved taken branch/jump (redirect this cycle)
//  dmem_req       in   1  MEM stage has an active load/store
//  dmem_ready     in   1  data memory completes access this cycle
//  pc_stall       out  1  hold PC
//  if_id_stall    out  1  hold IF/ID register
//  if_id_flush    out  1  zero IF/ID (insert NOP)
//  id_ex_stall    out  1  hold ID/EX register
//  id_ex_flush    out  1  zero ID/EX controls (bubble)
//  ex_mem_stall   out  1  hold EX/MEM register
//  mem_wb_bubble  out  1  write NOP into MEM/WB
//  hazard_err     out  1  sticky watchdog error
//  perf_stall     out  32 stall cycle count (see CONFIGURATION)
//  perf_flush     out  32 branch flush count (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//   - state=RUN, counters=0
//   - all outputs 0 while rst_n low (combinational outputs gated by reset)
//  States: RUN, LDSTALL, MEMWAIT, ERR. Outputs are combinational from state+inputs, so they act in the same cycle.
//  Hazard terms:
//   - memwait = dmem_req & ~dmem_ready
//   - ldhaz   = id_ex_memread & id_ex_rd!=0 & ((id_use_rs1 & id_rs1==id_ex_rd) | (id_use_rs2 & id_rs2==id_ex_rd))
//  Priority: ERR > memwait > ex_br_taken > LDSTALL/ldhaz.
//  memwait (any state except ERR):
//   - assert pc/if_id/id_ex/ex_mem stalls and mem_wb_bubble; go to / stay in MEMWAIT
//   - wait counter +1 per cycle; at count==MEM_TIMEOUT with memwait still high -> ERR
//   - LDSTALL remaining count is frozen, then resumed when the wait ends
//  MEMWAIT exit (dmem_ready=1 or dmem_req=0): no freeze this cycle; wait counter cleared;
//   next state = LDSTALL if bubbles remain, else RUN.
//  ex_br_taken (no memwait):
//   - if_id_flush=1, id_ex_flush=1, pc_stall=0 (PC loads target)
//   - any LDSTALL is cancelled -> RUN; fixed 2-cycle penalty
//   - ldhaz in the same cycle is ignored (victim instr is flushed anyway)
//  ldhaz in RUN: pc_stall=1, if_id_stall=1, id_ex_flush=1 (bubble 1).
//   - LOAD_LAT>1: enter LDSTALL with cnt=LOAD_LAT-1
//   - LDSTALL keeps the same three outputs, cnt-1 per cycle, -> RUN when cnt reaches 0
//   - ldhaz is not re-evaluated while in LDSTALL
//  ERR: all stalls asserted, mem_wb_bubble=1, hazard_err=1. Exits only via rst_n.
//  Reset mid-operation: async return to RUN, all counts cleared; no partial bubble carried over.
//  Width: wait counter is $clog2(MEM_TIMEOUT+1) bits; saturation is impossible because ERR is entered first.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - perf_stall +1 each cycle pc_stall=1
//   - perf_flush +1 each cycle ex_br_taken takes effect
//   - both 32-bit wrapping counters, cleared on reset
//  Not defined: perf_stall and perf_flush tied to 0; no counter flops.
// TESTING
//  1. LOAD_LAT=1; lw x5 in EX, ID reads rs1=x5 -> exactly 1 cycle pc_stall/if_id_stall/id_ex_flush, then RUN.
//  2. LOAD_LAT=2; same hazard -> 2 consecutive stall cycles. rd=x0 or id_use_rs1=0 -> no stall.
//  3. dmem_req=1, dmem_ready low for 4 cycles -> 4 frozen cycles with mem_wb_bubble=1, release on 5th.
//  4. ldhaz and ex_br_taken in same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0, state RUN.
//  5. MEM_TIMEOUT=8; dmem_ready held 0 -> hazard_err=1 after 8 wait cycles, stays set until rst_n.
//  6. HAZARD_PERF_EN: run tests 1 and 4 -> perf_stall=1, perf_flush=1. rst_n pulse mid-LDSTALL -> all outputs 0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, branch flushes, dmem wait freeze and wait watchdog.
// Optional perf counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic        ex_br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_bubble,
  output logic        hazard_err,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
);

  // state   | meaning
  // RUN     | normal issue, ldhaz evaluated
  // LDSTALL | extra load-use bubbles pending (ld_cnt > 0)
  // MEMWAIT | data memory wait, whole pipe frozen
  // ERR     | watchdog expired, sticky until reset
  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT, ERR} state_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(MEM_TIMEOUT);

  state_t        state, state_nxt;
  logic [1:0]    ld_cnt, ld_cnt_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          memwait, ldhaz, resume_ld;
  logic          pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c;
  logic          id_ex_flush_c, ex_mem_stall_c, mem_wb_bubble_c, hazard_err_c;

  assign memwait = dmem_req & ~dmem_ready;
  assign ldhaz   = id_ex_memread & (id_ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == id_ex_rd)) | (id_use_rs2 & (id_rs2 == id_ex_rd)));
  // Leaving MEMWAIT behaves as whichever state was frozen: pending bubbles resume immediately.
  assign resume_ld = (state == LDSTALL) || ((state == MEMWAIT) && (ld_cnt != 2'd0));

  always_comb begin
    state_nxt       = state;
    ld_cnt_nxt      = ld_cnt;
    wait_cnt_nxt    = '0;
    pc_stall_c      = 1'b0;
    if_id_stall_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_stall_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    ex_mem_stall_c  = 1'b0;
    mem_wb_bubble_c = 1'b0;
    hazard_err_c    = 1'b0;
    if (state == ERR) begin
      pc_stall_c      = 1'b1;
      if_id_stall_c   = 1'b1;
      id_ex_stall_c   = 1'b1;
      ex_mem_stall_c  = 1'b1;
      mem_wb_bubble_c = 1'b1;
      hazard_err_c    = 1'b1;
    end else if (memwait) begin
      pc_stall_c      = 1'b1;
      if_id_stall_c   = 1'b1;
      id_ex_stall_c   = 1'b1;
      ex_mem_stall_c  = 1'b1;
      mem_wb_bubble_c = 1'b1;
      wait_cnt_nxt    = wait_cnt + 1'b1;
      state_nxt       = (wait_cnt_nxt == TIMEOUT_W) ? ERR : MEMWAIT;
    end else if (ex_br_taken) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      ld_cnt_nxt    = 2'd0;
      state_nxt     = RUN;
    end else if (resume_ld) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
      ld_cnt_nxt    = ld_cnt - 2'd1;
      state_nxt     = (ld_cnt == 2'd1) ? RUN : LDSTALL;
    end else if (ldhaz) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
      ld_cnt_nxt    = 2'(LOAD_LAT - 1);
      state_nxt     = (LOAD_LAT > 1) ? LDSTALL : RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      ld_cnt   <= 2'd0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ld_cnt   <= ld_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign pc_stall      = rst_n & pc_stall_c;
  assign if_id_stall   = rst_n & if_id_stall_c;
  assign if_id_flush   = rst_n & if_id_flush_c;
  assign id_ex_stall   = rst_n & id_ex_stall_c;
  assign id_ex_flush   = rst_n & id_ex_flush_c;
  assign ex_mem_stall  = rst_n & ex_mem_stall_c;
  assign mem_wb_bubble = rst_n & mem_wb_bubble_c;
  assign hazard_err    = rst_n & hazard_err_c;

`ifdef HAZARD_PERF_EN
  logic        br_eff;
  logic [31:0] perf_stall_q, perf_flush_q;

  assign br_eff = (state != ERR) & ~memwait & ex_br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (pc_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (br_eff)   perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard cases plus random traffic against a rule-level model.
module tb_hazard_ctrl;
  localparam int LOAD_LAT    = 2;
  localparam int MEM_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, id_ex_memread = 0;
  logic        ex_br_taken = 0, dmem_req = 0, dmem_ready = 0;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_bubble, hazard_err;
  logic [31:0] perf_stall, perf_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(LOAD_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .ex_br_taken(ex_br_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .hazard_err(hazard_err),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, hazard_err}
  wire [7:0] ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                    id_ex_flush, ex_mem_stall, mem_wb_bubble, hazard_err};

  localparam logic [7:0] EXP_ERR  = 8'b1101_0111;
  localparam logic [7:0] EXP_WAIT = 8'b1101_0110;
  localparam logic [7:0] EXP_BR   = 8'b0010_1000;
  localparam logic [7:0] EXP_LD   = 8'b1100_1000;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bubbles owed, consecutive wait cycles, sticky error, event counts.
  int          m_bubbles, m_waits;
  bit          m_err;
  logic [31:0] m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic model_reset();
    m_bubbles = 0;
    m_waits   = 0;
    m_err     = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  task automatic check_perf(input string tag);
    chk({tag, "_perf_stall"}, perf_stall, perf_exp(m_stall));
    chk({tag, "_perf_flush"}, perf_flush, perf_exp(m_flush));
  endtask

  // Called at a falling edge: apply inputs, check mid-cycle, advance model, wait for next falling edge.
  task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic mr, input logic [4:0] rd, input logic br,
                       input logic req, input logic rdy);
    logic [7:0] exp;
    bit         ldhaz, memw;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_ex_memread = mr; id_ex_rd = rd; ex_br_taken = br; dmem_req = req; dmem_ready = rdy;
    #2;
    ldhaz = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    memw  = req && !rdy;
    exp   = 8'h00;
    if (m_err) begin
      exp = EXP_ERR;
    end else if (memw) begin
      exp = EXP_WAIT;
      m_waits++;
      if (m_waits == MEM_TIMEOUT) m_err = 1;
    end else begin
      m_waits = 0;
      if (br) begin
        exp = EXP_BR;
        m_bubbles = 0;
        m_flush++;
      end else if (m_bubbles > 0) begin
        exp = EXP_LD;
        m_bubbles--;
      end else if (ldhaz) begin
        exp = EXP_LD;
        m_bubbles = LOAD_LAT - 1;
      end
    end
    chk("ctl", {24'd0, ctl}, {24'd0, exp});
    if (exp[7]) m_stall++;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  // Asserts reset mid-cycle with hazard-provoking inputs, then releases it on the next falling edge.
  task automatic pulse_reset(input string tag);
    id_ex_memread = 1; id_ex_rd = 5'd5; id_use_rs1 = 1; id_rs1 = 5'd5;
    dmem_req = 1; dmem_ready = 0; ex_br_taken = 1;
    rst_n = 1'b0;
    #1;
    chk({tag, "_ctl"}, {24'd0, ctl}, 32'd0);
    chk({tag, "_perf_stall"}, perf_stall, 32'd0);
    chk({tag, "_perf_flush"}, perf_flush, 32'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    pulse_reset("reset");

    // Load-use on rs1: LOAD_LAT consecutive stall cycles, then clean.
    cycle(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0);
    cycle(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0);
    idle();
    // rd = x0 and unused rs1 never stall.
    cycle(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0);
    cycle(5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 0);
    // Load-use on rs2.
    cycle(5'd0, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0);
    idle();
    idle();
    // Four wait cycles, release on the fifth.
    repeat (4) cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
    // Branch wins over a simultaneous load-use.
    cycle(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0);
    idle();
    // Branch cancels a pending bubble.
    cycle(5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0);
    cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
    idle();
    // Wait arriving mid-bubble freezes it; the bubble resumes after release.
    cycle(5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0);
    repeat (2) cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
    idle();
    check_perf("dir");

    for (int i = 0; i < 1500; i++) begin
      cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    check_perf("rnd");

    // Reset in the middle of a load-use bubble leaves nothing behind.
    pulse_reset("rst_pre");
    cycle(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0);
    pulse_reset("rst_mid");
    idle();
    idle();

    // Watchdog: error after MEM_TIMEOUT wait cycles, sticky afterwards.
    repeat (MEM_TIMEOUT) cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    repeat (4) cycle(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 1);
    chk("err_sticky", {31'd0, hazard_err}, 32'd1);
    check_perf("err");
    pulse_reset("rst_err");
    idle();
    chk("err_cleared", {31'd0, hazard_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, limit 500000 reached");
    $fatal(1);
  end
endmodule
